// File: rtl/poly_mult_stream_wrap.sv
// Stream front/back end for a packed combinational polynomial multiplier:
// loads a/b coefficient streams, waits SETTLE cycles, then streams the product out.
module poly_mult_stream_wrap #(
    parameter int unsigned N      = 17,
    parameter int unsigned D      = 8,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_last,
    output logic [D*N-1:0]   mult_a,
    output logic [D*N-1:0]   mult_b,
    input  logic [D*N-1:0]   mult_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_c,
    output logic             out_last,
    output logic             busy,
    output logic             short_frame
);

    localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(D - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        StLoad,
        StWait,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [D*N-1:0]   a_q, a_d;
    logic [D*N-1:0]   b_q, b_d;
    logic [D*N-1:0]   c_q, c_d;
    logic             short_q, short_d;

    // Ready depends on state only, never on in_valid.
    assign in_ready    = (state_q == StLoad) && !rst;
    assign out_valid   = (state_q == StDrain) && !rst;
    assign busy        = ((state_q == StWait) || (state_q == StDrain)) && !rst;
    assign out_last    = out_valid && (idx_q == IDX_LAST);
    assign mult_a      = a_q;
    assign mult_b      = b_q;
    assign short_frame = short_q;

    always_comb begin
        out_c = '0;
        for (int i = 0; i < int'(D); i++) begin
            if (idx_q == IW'(i)) begin
                out_c = c_q[i*N +: N];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        short_d = short_q;
        case (state_q)
            StLoad: begin
                if (in_valid && in_ready) begin
                    for (int i = 0; i < int'(D); i++) begin
                        if (idx_q == IW'(i)) begin
                            a_d[i*N +: N] = in_a;
                            b_d[i*N +: N] = in_b;
                        end
                    end
                    if (idx_q == '0) begin
                        short_d = 1'b0;
                    end
                    if (in_last || (idx_q == IDX_LAST)) begin
                        state_d = StWait;
                        cnt_d   = '0;
                        idx_d   = '0;
                        // Unfilled slots stay zero from the clear on LOAD entry.
                        if (idx_q != IDX_LAST) begin
                            short_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == CNT_LAST) begin
                    c_d     = mult_c;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDrain: begin
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = StLoad;
                        idx_d   = '0;
                        a_d     = '0;
                        b_d     = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = StLoad;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoad;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            short_q <= short_d;
        end
    end

endmodule
